// File: rtl/up_copy_ctrl.sv
// Word-granular memory-to-memory copy engine.
// One read then one write per word, with byte-masked final write.
module up_copy_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [SIZE_WIDTH-1:0] size_i,
  input  logic                  int_en_i,
  input  logic                  trigger_i,
  input  logic                  clr_int_i,
  output logic                  busy_o,
  output logic                  int_pending_o,
  output logic                  int_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [SIZE_WIDTH:0]   words_q, words_init;
  logic [1:0]            tail_q;
  logic [31:0]           buf_q;
  logic                  pend_q;
  logic                  last;
  logic                  start;

  assign words_init = ({1'b0, size_i} + (SIZE_WIDTH+1)'(3)) >> 2;
  assign last  = (words_q == (SIZE_WIDTH+1)'(1));
  assign start = (state_q == IDLE) && trigger_i;

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trigger_i)
                 state_d = (size_i == '0) ? DONE : RD_REQ;
      RD_REQ:  if (mem_gnt_i)    state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i) state_d = WR_REQ;
      WR_REQ:  if (mem_gnt_i)    state_d = WR_WAIT;
      WR_WAIT: if (mem_rvalid_i)
                 state_d = last ? DONE : RD_REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      words_q  <= '0;
      tail_q   <= '0;
      buf_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (start && size_i != '0) begin
        rd_ptr_q <= {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wr_ptr_q <= {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
        words_q  <= words_init;
        tail_q   <= size_i[1:0];
      end
      if (state_q == RD_WAIT && mem_rvalid_i)
        buf_q <= mem_rdata_i;
      if (state_q == WR_WAIT && mem_rvalid_i && !last) begin
        words_q  <= words_q - (SIZE_WIDTH+1)'(1);
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(4);
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(4);
      end
      // completion beats a coincident clear
      if (state_q == DONE) pend_q <= 1'b1;
      else if (clr_int_i)  pend_q <= 1'b0;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'h0;
    unique case (state_q)
      RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = rd_ptr_q;
        mem_be_o   = 4'hF;
      end
      WR_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wr_ptr_q;
        mem_wdata_o = buf_q;
        mem_be_o    = 4'hF;
        if (last) begin
          unique case (tail_q)
            2'd1:    mem_be_o = 4'h1;
            2'd2:    mem_be_o = 4'h3;
            2'd3:    mem_be_o = 4'h7;
            default: mem_be_o = 4'hF;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign int_pending_o = pend_q;
  assign int_o         = pend_q & int_en_i;

endmodule
